// File: rtl/serial_tx_param.sv
// serial_tx_param: valid/ready word intake into a one-entry holding register, serialised MSB-first
// as start bit, DATA_W data bits, optional parity bit and a programmable low idle gap.
module serial_tx_param #(
    parameter int DATA_W = 55,
    parameter int PARITY = 0,
    parameter int GAP    = 1
) (
    input  logic              Clk_S,
    input  logic              Rst,
    input  logic [DATA_W-1:0] TX_Data,
    input  logic              TX_Data_Valid,
    output logic              TX_Ready,
    output logic              S_Data,
    output logic              TX_Busy,
    output logic              Frame_Done
);
    localparam int BW = $clog2(DATA_W + 1);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_GAP} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic              hold_valid_q, hold_valid_d;
    logic              par_q, par_d;
    logic              sdata_q, sdata_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept, load, to_gap;

    assign accept = TX_Data_Valid & ready_q;
    // A held word is loaded from IDLE or at the end of the last gap cycle, giving back-to-back frames.
    assign load   = hold_valid_q & ((state_q == S_IDLE) | ((state_q == S_GAP) & (gap_cnt_q == '0)));

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        hold_valid_d = hold_valid_q;
        par_d        = par_q;
        sdata_d      = sdata_q;
        done_d       = 1'b0;
        to_gap       = 1'b0;
        if (accept) begin
            hold_d       = TX_Data;
            hold_valid_d = 1'b1;
        end
        case (state_q)
            S_IDLE: sdata_d = 1'b0;
            S_START: begin
                state_d   = S_DATA;
                sdata_d   = shift_q[DATA_W-1];
                shift_d   = shift_q << 1;
                bit_cnt_d = BW'(DATA_W - 1);
            end
            S_DATA: begin
                if (bit_cnt_q != '0) begin
                    sdata_d   = shift_q[DATA_W-1];
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q - BW'(1);
                end else if (PARITY != 0) begin
                    state_d = S_PAR;
                    sdata_d = par_q;
                end else begin
                    to_gap = 1'b1;
                end
            end
            S_PAR: to_gap = 1'b1;
            S_GAP: begin
                sdata_d = 1'b0;
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                    done_d    = gap_cnt_q == GW'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (to_gap) begin
            state_d   = S_GAP;
            sdata_d   = 1'b0;
            gap_cnt_d = GW'(GAP - 1);
            done_d    = GAP == 1;
        end
        if (load) begin
            state_d      = S_START;
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
            sdata_d      = 1'b1;
            par_d        = (^hold_q) ^ (PARITY == 2);
        end
    end

    assign ready_d = ~hold_valid_d;
    assign busy_d  = (state_d != S_IDLE) | hold_valid_d;

    always_ff @(posedge Clk_S or posedge Rst) begin
        if (Rst) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            hold_valid_q <= 1'b0;
            par_q        <= 1'b0;
            sdata_q      <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            hold_valid_q <= hold_valid_d;
            par_q        <= par_d;
            sdata_q      <= sdata_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign TX_Ready   = ready_q;
    assign S_Data     = sdata_q;
    assign TX_Busy    = busy_q;
    assign Frame_Done = done_q;
endmodule

// File: tb/tb_serial_tx_param.sv
// tb_serial_tx_param: directed frames on four parameterisations of serial_tx_param sharing clock and reset.
module tb_serial_tx_param;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  vld = '0;
    logic [7:0]  d0 = '0, d1 = '0, d2 = '0;
    logic [54:0] d3 = '0;
    logic        sd0, sd1, sd2, sd3, rd0, rd1, rd2, rd3, bz0, bz1, bz2, bz3, dn0, dn1, dn2, dn3;
    wire  [3:0]  sd = {sd3, sd2, sd1, sd0};
    wire  [3:0]  rd = {rd3, rd2, rd1, rd0};
    wire  [3:0]  dn = {dn3, dn2, dn1, dn0};
    int          n_chk = 0, n_pass = 0;
    logic [63:0] sv, dv;
    int          rl, cnt;

    always #5 clk = ~clk;

    serial_tx_param #(.DATA_W(8),  .PARITY(1), .GAP(2)) u_even (.Clk_S(clk), .Rst(rst), .TX_Data(d0),
        .TX_Data_Valid(vld[0]), .TX_Ready(rd0), .S_Data(sd0), .TX_Busy(bz0), .Frame_Done(dn0));
    serial_tx_param #(.DATA_W(8),  .PARITY(2), .GAP(2)) u_odd (.Clk_S(clk), .Rst(rst), .TX_Data(d1),
        .TX_Data_Valid(vld[1]), .TX_Ready(rd1), .S_Data(sd1), .TX_Busy(bz1), .Frame_Done(dn1));
    serial_tx_param #(.DATA_W(8),  .PARITY(0), .GAP(2)) u_none (.Clk_S(clk), .Rst(rst), .TX_Data(d2),
        .TX_Data_Valid(vld[2]), .TX_Ready(rd2), .S_Data(sd2), .TX_Busy(bz2), .Frame_Done(dn2));
    serial_tx_param #(.DATA_W(55), .PARITY(1), .GAP(2)) u_wide (.Clk_S(clk), .Rst(rst), .TX_Data(d3),
        .TX_Data_Valid(vld[3]), .TX_Ready(rd3), .S_Data(sd3), .TX_Busy(bz3), .Frame_Done(dn3));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input int k, input int n, input int hold, output logic [63:0] s, output logic [63:0] d,
                       output int low);
        s = '0; d = '0; low = 0;
        if (hold == 0) vld[k] = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i + 1 == hold) vld[k] = 1'b0;
            s = {s[62:0], sd[k]};
            d = {d[62:0], dn[k]};
            if (!rd[k]) low++;
        end
    endtask

    initial begin
        tick(); tick();
        check("rst_sdata", 64'(sd0), 64'd0);
        check("rst_ready", 64'(rd0), 64'd0);
        check("rst_busy",  64'(bz0), 64'd0);
        check("rst_done",  64'(dn0), 64'd0);
        rst = 1'b0;
        check("ready_before_edge", 64'(rd0), 64'd0);
        tick();
        check("ready_after_release", 64'(rd0), 64'd1);

        d0 = 8'hA5; vld[0] = 1'b1; tick();
        check("t1_ready_low_after_accept", 64'(rd0), 64'd0);
        check("t1_busy_after_accept", 64'(bz0), 64'd1);
        cap(0, 12, 0, sv, dv, rl);
        check("t1_bits", sv, 64'({1'b1, 8'hA5, 1'b0, 2'b00}));
        check("t1_done", dv, 64'd1);
        check("t1_ready_low_in_frame", 64'(rl), 64'd0);
        tick();
        check("t1_idle_busy", 64'(bz0), 64'd0);

        d0 = 8'h01; vld[0] = 1'b1; tick();
        d0 = 8'h80;
        cap(0, 24, 2, sv, dv, rl);
        check("t2_bits", sv, 64'({1'b1, 8'h01, 1'b1, 2'b00, 1'b1, 8'h80, 1'b1, 2'b00}));
        check("t2_done", dv, 64'({12'd1, 12'd1}));
        check("t2_ready_low_while_held", 64'(rl), 64'd11);
        tick();

        d1 = 8'hFF; vld[1] = 1'b1; tick();
        cap(1, 12, 0, sv, dv, rl);
        check("t3_odd_bits", sv, 64'({1'b1, 8'hFF, 1'b1, 2'b00}));
        check("t3_odd_done", dv, 64'd1);
        d2 = 8'hFF; vld[2] = 1'b1; tick();
        cap(2, 11, 0, sv, dv, rl);
        check("t3_none_bits", sv, 64'({1'b1, 8'hFF, 2'b00}));
        check("t3_none_done", dv, 64'd1);
        tick();
        check("t3_none_idle", 64'(bz2), 64'd0);

        d3 = {1'b1, 54'b0}; vld[3] = 1'b1; tick();
        cap(3, 59, 0, sv, dv, rl);
        check("t4_wide_bits", sv, 64'({1'b1, 1'b1, 54'b0, 1'b1, 2'b00}));
        check("t4_wide_done", dv, 64'd1);
        tick();
        check("t4_wide_idle", 64'(bz3), 64'd0);

        d0 = 8'h3C; vld[0] = 1'b1; tick();
        d0 = 8'hC3; tick(); tick();
        vld[0] = 1'b0; tick(); tick(); tick();
        check("t5_fourth_bit", 64'(sd0), 64'd1);
        check("t5_held_ready", 64'(rd0), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_sdata", 64'(sd0), 64'd0);
        check("t5_rst_ready", 64'(rd0), 64'd0);
        check("t5_rst_busy",  64'(bz0), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        check("t5_ready_after_release", 64'(rd0), 64'd1);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (sd0 || bz0) cnt++;
        end
        check("t5_no_stale_frame", 64'(cnt), 64'd0);

        d0 = 8'h5A; vld[0] = 1'b1; tick();
        d0 = 8'hFF;
        cap(0, 12, 1, sv, dv, rl);
        check("t6_bits", sv, 64'({1'b1, 8'h5A, 1'b0, 2'b00}));
        tick();
        check("t6_no_extra_word", 64'(bz0), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
